// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with phase strobes and glitch-free reload.
// Optional feature: define CLKDIV_SYNC_START_EN to add the sync_start phase-alignment input.

module ClockDividerChannel #(
   parameter int CNT_W    = 16,
   parameter int DEF_HALF = 249
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             chEn_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] halfPeriod_i,
   input  logic             syncStart_i,
   output logic             divOut_o,
   output logic             risePls_o,
   output logic             fallPls_o,
   output logic             midLoPls_o,
   output logic             midHiPls_o,
   output logic             pend_o
);

   typedef enum logic {
      ST_PARKED = 1'b0,
      ST_RUN    = 1'b1
   } chState_e;

   chState_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] nAct_q, nAct_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             div_q, div_d;
   logic             pend_q, pend_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             midLo_q, midLo_d;
   logic             midHi_q, midHi_d;
   logic             applyShadow;
   logic             atTerm;
   logic             atMid;

   assign atTerm = (cnt_q == nAct_q);
   assign atMid  = (cnt_q == (nAct_q >> 1));

   // Next-state decode; sync beats park beats the normal toggle, and the shadow
   // only reaches the active N on a fall, on park entry, or on sync.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      nAct_d      = nAct_q;
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      midLo_d     = 1'b0;
      midHi_d     = 1'b0;
      applyShadow = 1'b0;

      if (syncStart_i && chEn_i) begin
         state_d     = ST_RUN;
         cnt_d       = '0;
         div_d       = 1'b0;
         applyShadow = 1'b1;
      end else if (state_q == ST_PARKED) begin
         applyShadow = 1'b1;
         if (chEn_i) begin
            state_d = ST_RUN;
         end
      end else if (!chEn_i && !div_q) begin
         state_d     = ST_PARKED;
         cnt_d       = '0;
         applyShadow = 1'b1;
      end else begin
         midLo_d = atMid && !div_q;
         midHi_d = atMid && div_q;
         if (atTerm) begin
            cnt_d = '0;
            div_d = !div_q;
            if (div_q) begin
               fall_d      = 1'b1;
               applyShadow = 1'b1;
               if (!chEn_i) begin
                  state_d = ST_PARKED;
               end
            end else begin
               rise_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (applyShadow) begin
         nAct_d = shadow_q;
         pend_d = 1'b0;
      end

      // A load in the apply cycle still wins the shadow and keeps pend set.
      if (load_i) begin
         shadow_d = halfPeriod_i;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_PARKED;
         cnt_q    <= '0;
         nAct_q   <= CNT_W'(DEF_HALF);
         shadow_q <= CNT_W'(DEF_HALF);
         div_q    <= 1'b0;
         pend_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         midLo_q  <= 1'b0;
         midHi_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         nAct_q   <= nAct_d;
         shadow_q <= shadow_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         midLo_q  <= midLo_d;
         midHi_q  <= midHi_d;
      end
   end

   assign divOut_o   = div_q;
   assign risePls_o  = rise_q;
   assign fallPls_o  = fall_q;
   assign midLoPls_o = midLo_q;
   assign midHiPls_o = midHi_q;
   assign pend_o     = pend_q;

endmodule

module clock_divider_multi #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 16,
   parameter int DEF_HALF = 249
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       ch_en,
   input  logic [NUM_CH*CNT_W-1:0] half_period,
   input  logic [NUM_CH-1:0]       load,
`ifdef CLKDIV_SYNC_START_EN
   input  logic                    sync_start,
`endif
   output logic [NUM_CH-1:0]       div_out,
   output logic [NUM_CH-1:0]       rise_pls,
   output logic [NUM_CH-1:0]       fall_pls,
   output logic [NUM_CH-1:0]       mid_lo_pls,
   output logic [NUM_CH-1:0]       mid_hi_pls,
   output logic [NUM_CH-1:0]       pend
);

   logic syncStart;

`ifdef CLKDIV_SYNC_START_EN
   assign syncStart = sync_start;
`else
   assign syncStart = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
      ClockDividerChannel #(
         .CNT_W    (CNT_W),
         .DEF_HALF (DEF_HALF)
      ) u_ch (
         .clk          (clk),
         .resetn       (resetn),
         .chEn_i       (ch_en[g]),
         .load_i       (load[g]),
         .halfPeriod_i (half_period[g*CNT_W +: CNT_W]),
         .syncStart_i  (syncStart),
         .divOut_o     (div_out[g]),
         .risePls_o    (rise_pls[g]),
         .fallPls_o    (fall_pls[g]),
         .midLoPls_o   (mid_lo_pls[g]),
         .midHiPls_o   (mid_hi_pls[g]),
         .pend_o       (pend[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed scenarios plus a randomized run,
// all outputs compared every cycle against a time-based behavioural model.

module tb_clock_divider_multi;

   localparam int NUM_CH   = 2;
   localparam int CNT_W    = 16;
   localparam int DEF_HALF = 249;

   logic                    clk;
   logic                    resetn;
   logic [NUM_CH-1:0]       chEn;
   logic [NUM_CH*CNT_W-1:0] halfPeriod;
   logic [NUM_CH-1:0]       load;
   logic                    syncStart;
   logic [NUM_CH-1:0]       divOut;
   logic [NUM_CH-1:0]       risePls;
   logic [NUM_CH-1:0]       fallPls;
   logic [NUM_CH-1:0]       midLoPls;
   logic [NUM_CH-1:0]       midHiPls;
   logic [NUM_CH-1:0]       pend;

   int passCount = 0;
   int failCount = 0;
   int checkCount = 0;
   int cyc = 0;

   // Model: each phase is remembered by the cycle it began in and its length N+1.
   bit mRun[NUM_CH];
   bit mLevel[NUM_CH];
   bit mPend[NUM_CH];
   bit mRise[NUM_CH];
   bit mFall[NUM_CH];
   bit mMidLo[NUM_CH];
   bit mMidHi[NUM_CH];
   int mStart[NUM_CH];
   int mN[NUM_CH];
   int mShadow[NUM_CH];

   clock_divider_multi #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .ch_en       (chEn),
      .half_period (halfPeriod),
      .load        (load),
`ifdef CLKDIV_SYNC_START_EN
      .sync_start  (syncStart),
`endif
      .div_out     (divOut),
      .rise_pls    (risePls),
      .fall_pls    (fallPls),
      .mid_lo_pls  (midLoPls),
      .mid_hi_pls  (midHiPls),
      .pend        (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         mRun[ch]    = 0;
         mLevel[ch]  = 0;
         mPend[ch]   = 0;
         mRise[ch]   = 0;
         mFall[ch]   = 0;
         mMidLo[ch]  = 0;
         mMidHi[ch]  = 0;
         mStart[ch]  = 0;
         mN[ch]      = DEF_HALF;
         mShadow[ch] = DEF_HALF;
      end
   endtask

   task automatic modelStep();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int age;
         bit apply;
         bit en;
         en    = chEn[ch];
         age   = cyc - mStart[ch];
         apply = 0;
         mRise[ch]  = 0;
         mFall[ch]  = 0;
         mMidLo[ch] = 0;
         mMidHi[ch] = 0;
         if (syncStart && en) begin
            mRun[ch]   = 1;
            mLevel[ch] = 0;
            mStart[ch] = cyc + 1;
            apply      = 1;
         end else if (!mRun[ch]) begin
            apply = 1;
            if (en) begin
               mRun[ch]   = 1;
               mStart[ch] = cyc + 1;
            end
         end else if (!en && !mLevel[ch]) begin
            mRun[ch] = 0;
            apply    = 1;
         end else begin
            if (age == mN[ch] / 2) begin
               if (mLevel[ch]) mMidHi[ch] = 1;
               else            mMidLo[ch] = 1;
            end
            if (age == mN[ch]) begin
               if (mLevel[ch]) begin
                  mFall[ch] = 1;
                  apply     = 1;
                  if (!en) mRun[ch] = 0;
               end else begin
                  mRise[ch] = 1;
               end
               mLevel[ch] = ~mLevel[ch];
               mStart[ch] = cyc + 1;
            end
         end
         if (apply) begin
            mN[ch]   = mShadow[ch];
            mPend[ch] = 0;
         end
         if (load[ch]) begin
            mShadow[ch] = int'(halfPeriod[ch*CNT_W +: CNT_W]);
            mPend[ch]   = 1;
         end
      end
   endtask

   task automatic checkAll();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         checkOutput($sformatf("div_out[%0d]", ch), divOut[ch], mLevel[ch]);
         checkOutput($sformatf("rise_pls[%0d]", ch), risePls[ch], mRise[ch]);
         checkOutput($sformatf("fall_pls[%0d]", ch), fallPls[ch], mFall[ch]);
         checkOutput($sformatf("mid_lo_pls[%0d]", ch), midLoPls[ch], mMidLo[ch]);
         checkOutput($sformatf("mid_hi_pls[%0d]", ch), midHiPls[ch], mMidHi[ch]);
         checkOutput($sformatf("pend[%0d]", ch), pend[ch], mPend[ch]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      cyc++;
      @(negedge clk);
      checkAll();
   endtask

   task automatic applyStimulus(input int ch, input int n);
      halfPeriod[ch*CNT_W +: CNT_W] = CNT_W'(n);
      load[ch] = 1'b1;
      tick();
      load[ch] = 1'b0;
   endtask

   // kind: 0 rise, 1 fall, 2 mid-low, 3 mid-high; returns the cycle it was seen in
   task automatic waitPulse(input int kind, input int ch, input int limit, output int at);
      logic seen;
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         case (kind)
            0:       seen = risePls[ch];
            1:       seen = fallPls[ch];
            2:       seen = midLoPls[ch];
            default: seen = midHiPls[ch];
         endcase
         if (seen) at = cyc;
      end
      checkOutput($sformatf("waitPulse%0d_ch%0d", kind, ch), seen, 1'b1);
   endtask

   task automatic waitPendClear(input int ch, input int limit);
      for (int i = 0; i < limit && pend[ch] !== 1'b0; i++) begin
         tick();
      end
      checkOutput($sformatf("pendClear_ch%0d", ch), pend[ch], 1'b0);
   endtask

   initial begin
      int eCyc, a, b, r, f, r2, f2, quiet;
      int rise1, rise2, fall1, midLoAfter, ch1Act;

      resetn     = 1'b0;
      chEn       = '0;
      load       = '0;
      syncStart  = 1'b0;
      halfPeriod = {NUM_CH{CNT_W'(DEF_HALF)}};
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      checkAll();

      $display("[TB] step 1: default N, ch0 enabled");
      chEn  = 2'b01;
      eCyc  = cyc + 1;
      rise1 = -1; rise2 = -1; fall1 = -1; midLoAfter = -1; ch1Act = 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (risePls[0]) begin
            if (rise1 < 0)      rise1 = cyc;
            else if (rise2 < 0) rise2 = cyc;
         end
         if (fallPls[0] && fall1 < 0) fall1 = cyc;
         if (midLoPls[0] && fall1 >= 0 && cyc > fall1 && midLoAfter < 0) midLoAfter = cyc;
         if (divOut[1] || risePls[1] || fallPls[1] || midLoPls[1] || midHiPls[1]) ch1Act++;
      end
      checkValue("firstRiseDelay", rise1 - eCyc, 250);
      checkValue("highTime", fall1 - rise1, 250);
      checkValue("period", rise2 - rise1, 500);
      checkValue("midLoAfterFall", midLoAfter - fall1, 125);
      checkValue("ch1Idle", ch1Act, 0);

      $display("[TB] step 2: N=0 on ch0");
      applyStimulus(0, 0);
      waitPendClear(0, 600);
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkOutput($sformatf("n0_div_%0d", i), divOut[0], (i % 2) == 1);
         checkOutput($sformatf("n0_rise_%0d", i), risePls[0], (i % 2) == 1);
         checkOutput($sformatf("n0_fall_%0d", i), fallPls[0], (i % 2) == 0);
      end

      $display("[TB] step 3: mid-high reload");
      applyStimulus(0, 9);
      waitPendClear(0, 20);
      waitPulse(0, 0, 30, r);
      repeat (3) tick();
      applyStimulus(0, 4);
      checkOutput("pendAfterLoad", pend[0], 1'b1);
      waitPulse(1, 0, 20, f);
      checkValue("oldHighLen", f - r, 10);
      checkOutput("pendAtFall", pend[0], 1'b0);
      waitPulse(0, 0, 20, r2);
      checkValue("newLowLen", r2 - f, 5);
      waitPulse(1, 0, 20, f2);
      checkValue("newHighLen", f2 - r2, 5);

      $display("[TB] step 4: disable in high phase, then re-enable");
      waitPulse(0, 0, 20, r);
      tick();
      chEn[0] = 1'b0;
      waitPulse(1, 0, 20, f);
      quiet = 0;
      repeat (50) begin
         tick();
         if (divOut[0] || risePls[0] || fallPls[0] || midLoPls[0] || midHiPls[0]) quiet++;
      end
      checkValue("parkedQuiet", quiet, 0);
      chEn[0] = 1'b1;
      eCyc = cyc + 1;
      waitPulse(0, 0, 20, a);
      checkValue("reenableRise", a - eCyc, 5);

      $display("[TB] step 5: async reset with pending reload");
      applyStimulus(0, 7);
      tick();
      checkOutput("pendBeforeReset", pend[0], 1'b1);
      #2 resetn = 1'b0;
      #1;
      modelReset();
      checkValue("rstDiv", int'(divOut), 0);
      checkValue("rstRise", int'(risePls), 0);
      checkValue("rstFall", int'(fallPls), 0);
      checkValue("rstMid", int'(midLoPls | midHiPls), 0);
      checkValue("rstPend", int'(pend), 0);
      @(negedge clk);
      resetn = 1'b1;
      checkAll();
      eCyc = cyc + 1;
      waitPulse(0, 0, 300, a);
      checkValue("postResetDefN", a - eCyc, 250);

`ifdef CLKDIV_SYNC_START_EN
      $display("[TB] step 6: sync_start alignment");
      chEn = 2'b11;
      applyStimulus(0, 3);
      applyStimulus(1, 7);
      waitPendClear(0, 600);
      waitPendClear(1, 600);
      syncStart = 1'b1;
      tick();
      syncStart = 1'b0;
      eCyc = cyc;
      checkValue("syncLow", int'(divOut), 0);
      checkValue("syncNoFall", int'(fallPls), 0);
      waitPulse(0, 0, 10, a);
      checkValue("syncRise0", a - eCyc, 4);
      waitPulse(0, 1, 10, b);
      checkValue("syncRise1", b - eCyc, 8);
`else
      $display("[TB] step 6: sync_start port not present in this build");
`endif

      $display("[TB] step 7: randomized run");
      chEn = 2'b11;
      for (int i = 0; i < 600; i++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 15) == 0) chEn[ch] = ~chEn[ch];
            load[ch] = ($urandom_range(0, 11) == 0);
            if (load[ch]) halfPeriod[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
         end
`ifdef CLKDIV_SYNC_START_EN
         syncStart = ($urandom_range(0, 39) == 0);
`endif
         tick();
      end
      load      = '0;
      syncStart = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
